lpf: RTL and testbench

//   Second-order (biquad) IIR low-pass filter, direct form I, one sample per clock.

---
 rtl/lpf_pkg.sv | 35 +++
 rtl/lpf_mac.sv | 36 +++
 rtl/lpf.sv | 81 ++++++++
 tb/tb_lpf.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpf_pkg : shared widths, types and narrowing helper for the lpf biquad      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lpf_pkg;

  localparam int W     = 32;
  localparam int PROD_W = 2 * W;
  localparam int ACC_W = 2 * W + 3;

  typedef logic signed [W-1:0]      sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(W-1){1'b0}}};

  // Reduce a full-precision result to sample width (clamp or wrap).
  function automatic sample_t narrow(input acc_t v);
`ifdef LPF_SAT_EN
    if (v > acc_t'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (v < acc_t'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return v[W-1:0];
    end
`else
    return v[W-1:0];
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpf_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpf_mac : combinational numerator/feedback multiply-accumulate              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpf_mac
  import lpf_pkg::*;
(
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] y2,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  output acc_t                acc
);

  prod_t p_b0, p_b1, p_b2, p_a1, p_a2;

  always_comb begin
    p_b0 = prod_t'(b0) * prod_t'(x);
    p_b1 = prod_t'(b1) * prod_t'(x1);
    p_b2 = prod_t'(b2) * prod_t'(x2);
    p_a1 = prod_t'(a1) * prod_t'(y1);
    p_a2 = prod_t'(a2) * prod_t'(y2);
    // Three guard bits above the product width absorb the five-term sum.
    acc  = acc_t'(p_b0) + acc_t'(p_b1) + acc_t'(p_b2)
         - acc_t'(p_a1) - acc_t'(p_a2);
  end

endmodule
`default_nettype wire

// File: rtl/lpf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpf : direct-form-I biquad IIR low-pass, one sample per clock, 1-cycle lat. |
// | Optional saturation of the narrowed result: define LPF_SAT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpf
  import lpf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] data,
  output logic signed [W-1:0] out,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2
);

  sample_t x1_q, x1_d;
  sample_t x2_q, x2_d;
  sample_t y1_q, y1_d;
  sample_t y2_q, y2_d;
  sample_t out_q, out_d;

  acc_t    acc;
  acc_t    y_full;
  sample_t y_narrow;

  lpf_mac u_mac (
    .x   (data),
    .x1  (x1_q),
    .x2  (x2_q),
    .y1  (y1_q),
    .y2  (y2_q),
    .b0  (b0),
    .b1  (b1),
    .b2  (b2),
    .a1  (a1),
    .a2  (a2),
    .acc (acc)
  );

  always_comb begin
    // a0 of zero bypasses the divider instead of producing an undefined quotient.
    if (a0 == '0) begin
      y_full = acc;
    end else begin
      y_full = acc / acc_t'(a0);
    end
    y_narrow = narrow(y_full);

    out_d = y_narrow;
    x1_d  = data;
    x2_d  = x1_q;
    y1_d  = y_narrow;
    y2_d  = y1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
    end else begin
      out_q <= out_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      y1_q  <= y1_d;
      y2_q  <= y2_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_lpf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lpf : scoreboard bench for the lpf biquad with directed vectors          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lpf;

  logic               clk;
  logic               rst;
  logic signed [31:0] data;
  logic signed [31:0] out;
  logic signed [31:0] b0, b1, b2, a0, a1, a2;

  typedef struct {
    bit    chk;
    int    expv;
    int    tol;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  lpf dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .out  (out),
    .b0   (b0),
    .b1   (b1),
    .b2   (b2),
    .a0   (a0),
    .a1   (a1),
    .a2   (a2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One queue entry per rising edge; out is inspected just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        longint d;
        e = sb.pop_front();
        if (e.chk) begin
          d = longint'(out) - longint'(e.expv);
          if (d < 0) d = -d;
          n_checks++;
          if (d > longint'(e.tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", e.name, out, e.expv, e.tol);
          end
        end
      end
    end
  end

  task automatic cyc(input bit chk, input int expv, input int tol, input string name);
    sb.push_back('{chk, expv, tol, name});
    @(negedge clk);
  endtask

  task automatic now_check(input int expv, input string name);
    n_checks++;
    if (out !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, out, expv);
    end
  endtask

  task automatic set_coef(input int c_b0, input int c_b1, input int c_b2,
                          input int c_a0, input int c_a1, input int c_a2);
    b0 = c_b0; b1 = c_b1; b2 = c_b2;
    a0 = c_a0; a1 = c_a1; a2 = c_a2;
  endtask

  initial begin
    rst  = 1'b1;
    data = 12345;
    set_coef(13, 26, 13, 100, -74, 27);
    #1;
    now_check(0, "reset_async_t0");

    // Reset held: out stays zero regardless of data.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, "reset_hold");

    // Step response from cleared history.
    rst  = 1'b0;
    data = 10000;
    cyc(1, 1300, 0, "step_0");
    cyc(1, 4862, 0, "step_1");
    cyc(1, 8446, 0, "step_2");
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, "settle");
    cyc(1, 9811, 1, "step_converge");

    // Pass-through: only b0/a0 active, history left untouched.
    set_coef(100, 0, 0, 100, 0, 0);
    data = 20000; cyc(1, 20000, 0, "pass_0");
    data = 10000; cyc(1, 10000, 0, "pass_1");
    data = 24000; cyc(1, 24000, 0, "pass_2");

    // -150/100 truncates toward zero.
    set_coef(-1, 0, 0, 100, 0, 0);
    data = 150; cyc(1, -1, 0, "neg_trunc");

    // a0 == 0 skips division.
    set_coef(3, 0, 0, 0, 0, 0);
    data = 7; cyc(1, 21, 0, "div_zero_guard");

    // 0x7FFFFFFF * 2 exceeds the sample range.
    set_coef(32'h7FFFFFFF, 0, 0, 1, 0, 0);
    data = 2;
`ifdef LPF_SAT_EN
    cyc(1, 32'h7FFFFFFF, 0, "overflow_sat");
`else
    cyc(1, -2, 0, "overflow_wrap");
`endif

    // Mid-run reset: fresh start, three steps, async pulse, identical restart.
    rst = 1'b1;
    #1;
    now_check(0, "reset_async_pre");
    #1 rst = 1'b0;
    set_coef(13, 26, 13, 100, -74, 27);
    data = 10000;
    cyc(1, 1300, 0, "run_0");
    cyc(1, 4862, 0, "run_1");
    cyc(1, 8446, 0, "run_2");
    rst = 1'b1;
    #1;
    now_check(0, "reset_async_mid");
    #1 rst = 1'b0;
    cyc(1, 1300, 0, "rerun_0");
    cyc(1, 4862, 0, "rerun_1");
    cyc(1, 8446, 0, "rerun_2");

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    if (!stim_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: stimulus not complete, expected done");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
